modulo_seletor_regioes: RTL and testbench



---
 rtl/modulo_seletor_pkg.sv | 29 ++
 rtl/modulo_seletor_regioes_decodificador.sv | 17 +
 rtl/modulo_seletor_regioes.sv | 128 ++++++++++++
 tb/tb_modulo_seletor_regioes.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_seletor_pkg.sv
// Shared definitions for the region selector: FSM encoding and the
// elaboration-time helpers used to size and compute the channel index.
package modulo_seletor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    HOLD = 2'b10
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Regions are numbered row-major: region row first, then region column.
  function automatic int unsigned region_idx(input int unsigned col,
                                             input int unsigned line,
                                             input int unsigned cols,
                                             input int unsigned reg_w,
                                             input int unsigned reg_h);
    return (line / reg_h) * (cols / reg_w) + (col / reg_w);
  endfunction

endpackage

// File: rtl/modulo_seletor_regioes_decodificador.sv
// Index-to-one-hot decoder; output is all zeros while the enable is low.
module decodificador_onehot #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N-1:0]     onehot
);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/modulo_seletor_regioes.sv
// Registered (column, line) to demux-channel selector with a programmable
// hold window on the one-hot enable.
module modulo_seletor_regioes
  import modulo_seletor_pkg::*;
#(
  parameter  int COLS        = 8,
  parameter  int ROWS        = 8,
  parameter  int REG_W       = 4,
  parameter  int REG_H       = 2,
  parameter  int HOLD_CYCLES = 4,
  localparam int CW          = (clog2(COLS) < 1) ? 1 : clog2(COLS),
  localparam int RW          = (clog2(ROWS) < 1) ? 1 : clog2(ROWS),
  localparam int NCH         = (COLS / REG_W) * (ROWS / REG_H),
  localparam int SEL_W       = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    mdc,
  input  logic [RW-1:0]    mdl,
  input  logic             clear,
  output logic [SEL_W-1:0] dmx_sel,
  output logic [NCH-1:0]   dmx_en,
  output logic             out_valid,
  output logic             err,
  output logic             busy
);

  localparam int            HW        = (clog2(HOLD_CYCLES) < 1) ? 1 : clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [CW:0]   COLS_V    = (CW + 1)'(COLS);
  localparam logic [RW:0]   ROWS_V    = (RW + 1)'(ROWS);

  state_t           state, state_nx;
  logic [CW-1:0]    col_q, col_nx;
  logic [RW-1:0]    line_q, line_nx;
  logic [HW-1:0]    cnt_q, cnt_nx;
  logic [SEL_W-1:0] sel_q, sel_nx;
  logic             ov_nx, err_nx;
  logic             accept, in_range;
  logic [SEL_W-1:0] ch;

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready && !clear;
  assign busy     = (state != IDLE);
  assign dmx_sel  = sel_q;

  assign in_range = ({1'b0, col_q} < COLS_V) && ({1'b0, line_q} < ROWS_V);
  assign ch       = SEL_W'(region_idx(32'(col_q), 32'(line_q), COLS, REG_W, REG_H));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    col_nx   = col_q;
    line_nx  = line_q;
    cnt_nx   = cnt_q;
    sel_nx   = sel_q;
    ov_nx    = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          col_nx   = mdc;
          line_nx  = mdl;
          state_nx = CALC;
        end
      end
      CALC: begin
        if (clear) begin
          state_nx = IDLE;
        end else if (in_range) begin
          sel_nx   = ch;
          cnt_nx   = HOLD_LOAD;
          ov_nx    = 1'b1;
          state_nx = HOLD;
        end else begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (clear || (cnt_q == '0)) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_q - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col_q     <= '0;
      line_q    <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      col_q     <= col_nx;
      line_q    <= line_nx;
      cnt_q     <= cnt_nx;
      sel_q     <= sel_nx;
      out_valid <= ov_nx;
      err       <= err_nx;
    end
  end

  // Enable follows the HOLD state directly, so clear or reset drops it on the next edge.
  logic hold_on;
  assign hold_on = (state == HOLD);

  decodificador_onehot #(
    .N    (NCH),
    .SEL_W(SEL_W)
  ) u_dec (
    .sel   (sel_q),
    .en    (hold_on),
    .onehot(dmx_en)
  );

endmodule

// File: tb/tb_modulo_seletor_regioes.sv
// Self-checking bench: default 8x8 instance plus a 6x6 instance sharing the
// same request inputs, checked against a region-arithmetic reference model.
module tb_modulo_seletor_regioes;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] mdc = '0;
  logic [2:0] mdl = '0;

  logic       a_ready, a_ov, a_err, a_busy;
  logic [2:0] a_sel;
  logic [7:0] a_en;
  logic       b_ready, b_ov, b_err, b_busy;
  logic [2:0] b_sel;
  logic [5:0] b_en;

  int n_vec = 0;
  int n_err = 0;
  int last_sel[2];

  always #5 clk = ~clk;

  modulo_seletor_regioes dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ready),
    .mdc(mdc), .mdl(mdl), .clear(clear), .dmx_sel(a_sel), .dmx_en(a_en),
    .out_valid(a_ov), .err(a_err), .busy(a_busy)
  );

  modulo_seletor_regioes #(
    .COLS(6), .ROWS(6), .REG_W(3), .REG_H(2), .HOLD_CYCLES(H)
  ) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_ready),
    .mdc(mdc), .mdl(mdl), .clear(clear), .dmx_sel(b_sel), .dmx_en(b_en),
    .out_valid(b_ov), .err(b_err), .busy(b_busy)
  );

  typedef struct {
    logic [31:0] sel;
    logic [31:0] en;
    logic        ov, err, busy, rdy;
  } snap_t;

  typedef struct {
    int c;
    int l;
    int ch;
  } vec_t;

  function automatic snap_t get(input bit w);
    snap_t s;
    if (w) begin
      s.sel = 32'(b_sel); s.en = 32'(b_en);
      s.ov = b_ov; s.err = b_err; s.busy = b_busy; s.rdy = b_ready;
    end else begin
      s.sel = 32'(a_sel); s.en = 32'(a_en);
      s.ov = a_ov; s.err = a_err; s.busy = a_busy; s.rdy = a_ready;
    end
    return s;
  endfunction

  // Reference: grid geometry per instance; -1 means the coordinate is off-grid.
  function automatic int model_ch(input bit w, input int c, input int l);
    int cols, rows, rw, rh;
    cols = w ? 6 : 8; rows = w ? 6 : 8;
    rw   = w ? 3 : 4; rh   = 2;
    if (c >= cols || l >= rows) return -1;
    return (l / rh) * (cols / rw) + (c / rw);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(a_ready && b_ready) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(n), 32'd0);
  endtask

  // One request, checked cycle by cycle from the accepting edge.
  task automatic run_req(input bit w, input int c, input int l, input int exp_ch);
    snap_t s;
    int    other;
    wait_idle();
    mdc = 3'(c); mdl = 3'(l); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    s = get(w);
    check("calc_busy", 32'(s.busy), 1);
    check("calc_en", s.en, 0);
    step();
    s = get(w);
    check("t2_ov", 32'(s.ov && s.err), 0);
    if (exp_ch >= 0) begin
      check("t2_out_valid", 32'(s.ov), 1);
      check("t2_sel", s.sel, 32'(exp_ch));
      check("t2_en", s.en, 32'(1) << exp_ch);
      last_sel[w] = exp_ch;
      for (int k = 1; k < H; k++) begin
        step();
        s = get(w);
        check("hold_en", s.en, 32'(1) << exp_ch);
        check("hold_ov_low", 32'(s.ov), 0);
      end
      step();
      s = get(w);
      check("end_ready", 32'(s.rdy), 1);
      check("end_en", s.en, 0);
    end else begin
      check("err_pulse", 32'(s.err), 1);
      check("err_no_ov", 32'(s.ov), 0);
      check("err_en", s.en, 0);
      check("err_sel_kept", s.sel, 32'(last_sel[w]));
      check("err_ready", 32'(s.rdy), 1);
      step();
      s = get(w);
      check("err_one_cycle", 32'(s.err), 0);
    end
    other = model_ch(!w, c, l);
    if (other >= 0) last_sel[!w] = other;
    wait_idle();
  endtask

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, l;
    snap_t s;
    tbl = '{'{0, 0, 0}, '{7, 0, 1}, '{0, 7, 6}, '{7, 7, 7}, '{5, 3, 3},
            '{3, 1, 0}, '{4, 1, 1}, '{2, 2, 2}, '{6, 4, 5}};
    last_sel[0] = 0;
    last_sel[1] = 0;

    // Reset state
    repeat (3) step();
    check("rst_ready_a", 32'(a_ready), 0);
    check("rst_ready_b", 32'(b_ready), 0);
    reset = 1'b0;
    #1;
    s = get(0);
    check("rst_sel", s.sel, 0);
    check("rst_en", s.en, 0);
    check("rst_flags", {28'd0, s.ov, s.err, s.busy, 1'b0}, 0);
    check("rst_ready_after", 32'(s.rdy), 1);

    // Table-driven channel map (includes the four corners)
    for (int i = 0; i < 9; i++) run_req(0, tbl[i].c, tbl[i].l, tbl[i].ch);

    // Random requests on the 8x8 instance
    for (int i = 0; i < 16; i++) begin
      c = $urandom_range(0, 7);
      l = $urandom_range(0, 7);
      run_req(0, c, l, model_ch(0, c, l));
    end

    // Back-to-back with in_valid held high: (1,0) then (4,2)
    wait_idle();
    mdc = 3'd1; mdl = 3'd0; in_valid = 1'b1;
    step();
    check("b2b_calc1", 32'(a_busy), 1);
    step();
    check("b2b_ov1", 32'(a_ov), 1);
    check("b2b_sel1", 32'(a_sel), 32'(model_ch(0, 1, 0)));
    mdc = 3'd4; mdl = 3'd2;
    repeat (H - 1) step();
    check("b2b_en1_last", 32'(a_en), 32'(1) << model_ch(0, 1, 0));
    step();
    check("b2b_idle_ready", 32'(a_ready), 1);
    check("b2b_idle_en", 32'(a_en), 0);
    step();
    check("b2b_calc2", 32'(a_busy), 1);
    check("b2b_no_err", 32'(a_err || a_ov), 0);
    in_valid = 1'b0;
    step();
    check("b2b_ov2", 32'(a_ov), 1);
    check("b2b_sel2", 32'(a_sel), 32'(model_ch(0, 4, 2)));
    check("b2b_en2", 32'(a_en), 32'(1) << model_ch(0, 4, 2));
    repeat (H) step();
    check("b2b_end_ready", 32'(a_ready), 1);
    step();
    check("b2b_no_dup", 32'(a_busy), 0);

    // clear during HOLD, then clear beating in_valid in IDLE
    wait_idle();
    mdc = 3'd5; mdl = 3'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("clrh_en_t2", 32'(a_en), 32'h8);
    step();
    clear = 1'b1;
    step();
    check("clrh_en_off", 32'(a_en), 0);
    check("clrh_idle", 32'(a_busy), 0);
    in_valid = 1'b1;
    step();
    check("clr_beats_valid", 32'(a_busy), 0);
    clear = 1'b0;
    in_valid = 1'b0;

    // clear during CALC: no out_valid, no err, selection unchanged
    wait_idle();
    mdc = 3'd6; mdl = 3'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    check("clrc_flags_a", 32'(a_ov || a_err || a_busy), 0);
    check("clrc_en_a", 32'(a_en), 0);
    check("clrc_sel_a", 32'(a_sel), 3);
    check("clrc_err_b", 32'(b_err || b_ov), 0);
    clear = 1'b0;
    step();
    check("clrc_flags_later", 32'(a_ov || a_err || b_err || b_ov), 0);

    // reset in the middle of HOLD
    wait_idle();
    mdc = 3'd7; mdl = 3'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("rsth_sel", 32'(a_sel), 0);
    check("rsth_en", 32'(a_en), 0);
    check("rsth_busy_ov", 32'(a_busy || a_ov), 0);
    check("rsth_ready_low", 32'(a_ready), 0);
    reset = 1'b0;
    #1;
    check("rsth_ready_high", 32'(a_ready), 1);
    last_sel[0] = 0;
    last_sel[1] = 0;

    // 6x6 instance: in-range, column and line off-grid, random
    run_req(1, 4, 3, model_ch(1, 4, 3));
    run_req(1, 6, 1, -1);
    run_req(1, 2, 6, -1);
    run_req(1, 5, 5, 5);
    for (int i = 0; i < 16; i++) begin
      c = $urandom_range(0, 7);
      l = $urandom_range(0, 7);
      run_req(1, c, l, model_ch(1, c, l));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
